// File: rtl/riscv_core_rob_pkg.sv
// Shared widths and the in-flight tracker entry for the ROB dispatch path.
package riscv_core_rob_pkg;

    localparam int ROB_SLOT_W  = 4;
    localparam int ROB_PREG_W  = 5;
    localparam int ROB_MAX_LAT = 15;
    localparam int ROB_LAT_W   = $clog2(ROB_MAX_LAT + 1);

    typedef struct packed {
        logic                  valid;
        logic [ROB_SLOT_W-1:0] slot;
        logic [ROB_LAT_W-1:0]  cnt;
    } trk_entry_t;

endpackage

// File: rtl/riscv_core_rob_fill_arb.sv
// Fixed-priority picker: the lowest set request bit wins.
module riscv_core_rob_fill_arb #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any_valid
);

    localparam int IW = $clog2(N);

    always_comb begin
        gnt       = '0;
        idx       = '0;
        any_valid = 1'b0;
        // Scan downward so the lowest index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt       = '0;
                gnt[i]    = 1'b1;
                idx       = i[IW-1:0];
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/riscv_core_rob_dispatch.sv
// Dispatch side of the reorder buffer: allocates ROB slots, times execution
// latency per instruction, fills completed slots and blocks WAW on busy pregs.
module riscv_core_rob_dispatch
    import riscv_core_rob_pkg::*;
#(
    parameter int NUM_INFLIGHT = 4,
    parameter int LAT_W        = ROB_LAT_W,
    parameter int SLOT_W       = ROB_SLOT_W,
    parameter int PREG_W       = ROB_PREG_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          disp_val,
    output logic                          disp_rdy,
    input  logic [PREG_W-1:0]             disp_preg,
    input  logic [LAT_W-1:0]              disp_lat,
    output logic                          rob_alloc_req_val,
    input  logic                          rob_alloc_req_rdy,
    output logic [PREG_W-1:0]             rob_alloc_req_preg,
    input  logic [SLOT_W-1:0]             rob_alloc_resp_slot,
    output logic                          rob_fill_val,
    output logic [SLOT_W-1:0]             rob_fill_slot,
    input  logic                          rob_commit_wen,
    input  logic [SLOT_W-1:0]             rob_commit_slot,
    input  logic [PREG_W-1:0]             rob_commit_rf_waddr,
    output logic [$clog2(NUM_INFLIGHT):0] inflight_cnt
);

    localparam int IDX_W    = $clog2(NUM_INFLIGHT);
    localparam int NUM_PREG = 1 << PREG_W;

    trk_entry_t              trk [NUM_INFLIGHT];
    logic [NUM_INFLIGHT-1:0] vld_vec;
    logic [NUM_INFLIGHT-1:0] elig_vec;
    logic [NUM_INFLIGHT-1:0] fill_gnt;
    logic [NUM_INFLIGHT-1:0] free_gnt;
    logic [IDX_W-1:0]        fill_idx;
    logic [IDX_W-1:0]        free_idx;
    logic                    fill_any;
    logic                    free_any;
    logic [NUM_PREG-1:0]     busy;
    logic                    can_disp;
    logic                    fire;

    // A zero latency behaves as a single cycle.
    function automatic logic [LAT_W-1:0] lat_to_cnt(input logic [LAT_W-1:0] lat);
        lat_to_cnt = (lat == '0) ? '0 : lat - 1'b1;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_INFLIGHT; i++) begin
            vld_vec[i]  = trk[i].valid;
            elig_vec[i] = trk[i].valid && (trk[i].cnt == '0);
        end
    end

    riscv_core_rob_fill_arb #(.N(NUM_INFLIGHT)) u_fill_arb (
        .req       (elig_vec),
        .gnt       (fill_gnt),
        .idx       (fill_idx),
        .any_valid (fill_any)
    );

    riscv_core_rob_fill_arb #(.N(NUM_INFLIGHT)) u_free_arb (
        .req       (~vld_vec),
        .gnt       (free_gnt),
        .idx       (free_idx),
        .any_valid (free_any)
    );

    assign can_disp           = reset && free_any && !busy[disp_preg];
    assign rob_alloc_req_val  = disp_val && can_disp;
    assign disp_rdy           = rob_alloc_req_rdy && can_disp;
    assign rob_alloc_req_preg = disp_preg;
    assign fire               = disp_val && disp_rdy;
    assign rob_fill_val       = fill_any;
    assign rob_fill_slot      = trk[fill_idx].slot;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < NUM_INFLIGHT; i++) begin
            inflight_cnt = inflight_cnt + (IDX_W + 1)'(vld_vec[i]);
        end
    end

    // Only valid bits are reset; slot and cnt are qualified by valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_INFLIGHT; i++) begin
                trk[i].valid <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_INFLIGHT; i++) begin
                if (fire && free_gnt[i]) begin
                    trk[i].valid <= 1'b1;
                    trk[i].slot  <= rob_alloc_resp_slot;
                    trk[i].cnt   <= lat_to_cnt(disp_lat);
                end else begin
                    if (fill_gnt[i]) begin
                        trk[i].valid <= 1'b0;
                    end
                    if (trk[i].valid && (trk[i].cnt != '0)) begin
                        trk[i].cnt <= trk[i].cnt - 1'b1;
                    end
                end
            end
        end
    end

    // Set after clear so a stray commit never cancels a same-cycle dispatch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy <= '0;
        end else begin
            if (rob_commit_wen) begin
                busy[rob_commit_rf_waddr] <= 1'b0;
            end
            if (fire && (disp_preg != '0)) begin
                busy[disp_preg] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!rob_fill_val || |(fill_gnt & vld_vec))
                else $error("fill of a slot not held by a valid entry");
            assert (!fire || !vld_vec[free_idx])
                else $error("allocation into an occupied entry");
            for (int i = 0; i < NUM_INFLIGHT; i++) begin
                for (int j = i + 1; j < NUM_INFLIGHT; j++) begin
                    assert (!(trk[i].valid && trk[j].valid && (trk[i].slot == trk[j].slot)))
                        else $error("duplicate slot in tracker entries %0d and %0d", i, j);
                end
                assert (!(rob_commit_wen && trk[i].valid && (trk[i].slot == rob_commit_slot)))
                    else $error("commit of slot still executing in entry %0d", i);
            end
        end else begin
            assert (!rob_fill_val) else $error("fill asserted during reset");
        end
    end

endmodule

// File: tb/tb_riscv_core_rob_dispatch.sv
// Randomized and directed bench for riscv_core_rob_dispatch against a
// time-stamped reference model of the in-flight table and busy set.
module tb_riscv_core_rob_dispatch;

    localparam int N      = 4;
    localparam int LAT_W  = 4;
    localparam int SLOT_W = 4;
    localparam int PREG_W = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              disp_val = 1'b0;
    logic              disp_rdy;
    logic [PREG_W-1:0] disp_preg = '0;
    logic [LAT_W-1:0]  disp_lat = '0;
    logic              rob_alloc_req_val;
    logic              rob_alloc_req_rdy = 1'b0;
    logic [PREG_W-1:0] rob_alloc_req_preg;
    logic [SLOT_W-1:0] rob_alloc_resp_slot = '0;
    logic              rob_fill_val;
    logic [SLOT_W-1:0] rob_fill_slot;
    logic              rob_commit_wen = 1'b0;
    logic [SLOT_W-1:0] rob_commit_slot = '0;
    logic [PREG_W-1:0] rob_commit_rf_waddr = '0;
    logic [2:0]        inflight_cnt;

    always #5 clk = ~clk;

    riscv_core_rob_dispatch #(
        .NUM_INFLIGHT (N),
        .LAT_W        (LAT_W),
        .SLOT_W       (SLOT_W),
        .PREG_W       (PREG_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .disp_val            (disp_val),
        .disp_rdy            (disp_rdy),
        .disp_preg           (disp_preg),
        .disp_lat            (disp_lat),
        .rob_alloc_req_val   (rob_alloc_req_val),
        .rob_alloc_req_rdy   (rob_alloc_req_rdy),
        .rob_alloc_req_preg  (rob_alloc_req_preg),
        .rob_alloc_resp_slot (rob_alloc_resp_slot),
        .rob_fill_val        (rob_fill_val),
        .rob_fill_slot       (rob_fill_slot),
        .rob_commit_wen      (rob_commit_wen),
        .rob_commit_slot     (rob_commit_slot),
        .rob_commit_rf_waddr (rob_commit_rf_waddr),
        .inflight_cnt        (inflight_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: each pending instruction carries the absolute cycle it becomes fillable.
    typedef struct {
        int slot;
        int preg;
    } done_t;

    bit    m_valid [N];
    int    m_slot  [N];
    int    m_preg  [N];
    int    m_ready [N];
    bit    m_busy  [32];
    done_t done_q  [$];
    int    cyc = 0;

    logic       o_rdy, o_req, o_fill;
    logic [3:0] o_fslot;
    logic [2:0] o_cnt;

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
        for (int p = 0; p < 32; p++) m_busy[p] = 1'b0;
        done_q.delete();
    endtask

    task automatic step(input bit dv, input int preg, input int lat, input bit ardy,
                        input int slot, input bit cwen, input int cslot, input int cwaddr);
        int  exp_cnt;
        int  win;
        int  free_i;
        bit  exp_can;
        bit  exp_fill;
        @(negedge clk);
        disp_val            = dv;
        disp_preg           = PREG_W'(preg);
        disp_lat            = LAT_W'(lat);
        rob_alloc_req_rdy   = ardy;
        rob_alloc_resp_slot = SLOT_W'(slot);
        rob_commit_wen      = cwen;
        rob_commit_slot     = SLOT_W'(cslot);
        rob_commit_rf_waddr = PREG_W'(cwaddr);
        #1;
        exp_cnt = 0;
        for (int i = 0; i < N; i++) if (m_valid[i]) exp_cnt++;
        exp_can = (exp_cnt < N) && !m_busy[preg];
        win = -1;
        for (int i = 0; i < N; i++) if (win < 0 && m_valid[i] && cyc >= m_ready[i]) win = i;
        exp_fill = (win >= 0);
        o_rdy   = disp_rdy;
        o_req   = rob_alloc_req_val;
        o_fill  = rob_fill_val;
        o_fslot = rob_fill_slot;
        o_cnt   = inflight_cnt;
        check_eq("disp_rdy", o_rdy, ardy && exp_can);
        check_eq("alloc_val", o_req, dv && exp_can);
        check_eq("alloc_preg", rob_alloc_req_preg, preg);
        check_eq("fill_val", o_fill, exp_fill);
        if (exp_fill) check_eq("fill_slot", o_fslot, m_slot[win]);
        check_eq("inflight_cnt", o_cnt, exp_cnt);
        free_i = -1;
        for (int i = 0; i < N; i++) if (free_i < 0 && !m_valid[i]) free_i = i;
        if (exp_fill) begin
            m_valid[win] = 1'b0;
            done_q.push_back('{m_slot[win], m_preg[win]});
        end
        if (cwen) m_busy[cwaddr] = 1'b0;
        if (dv && ardy && exp_can) begin
            m_valid[free_i] = 1'b1;
            m_slot[free_i]  = slot;
            m_preg[free_i]  = preg;
            m_ready[free_i] = cyc + ((lat == 0) ? 1 : lat);
            if (preg != 0) m_busy[preg] = 1'b1;
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 0, 1, 1'b1, 0, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        disp_val          = 1'b1;
        disp_preg         = PREG_W'(3);
        rob_alloc_req_rdy = 1'b1;
        rob_commit_wen    = 1'b0;
        reset             = 1'b0;
        #1;
        check_eq("rst_fill_val", rob_fill_val, 0);
        check_eq("rst_alloc_val", rob_alloc_req_val, 0);
        check_eq("rst_inflight", inflight_cnt, 0);
        model_clear();
        @(negedge clk);
        disp_val = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic rand_step();
        bit    used [16];
        int    free_slots [$];
        int    preg, lat, slot, cslot, cwaddr, nused, p;
        bit    dv, ardy, cwen;
        done_t d;
        for (int s = 0; s < 16; s++) used[s] = 1'b0;
        for (int i = 0; i < N; i++) if (m_valid[i]) used[m_slot[i]] = 1'b1;
        foreach (done_q[k]) used[done_q[k].slot] = 1'b1;
        nused = 0;
        for (int s = 0; s < 16; s++) begin
            if (used[s]) nused++;
            else free_slots.push_back(s);
        end
        dv   = ($urandom_range(0, 3) != 0);
        preg = $urandom_range(0, 7);
        lat  = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 4);
        ardy = ($urandom_range(0, 3) != 0) && (nused < 12) && (free_slots.size() > 0);
        slot = (free_slots.size() > 0) ? free_slots[$urandom_range(0, free_slots.size() - 1)] : 0;
        cwen = 1'b0; cslot = 0; cwaddr = 0;
        if (done_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            d = done_q.pop_front();
            cwen = 1'b1; cslot = d.slot; cwaddr = d.preg;
        end else if ($urandom_range(0, 7) == 0 && free_slots.size() > 0) begin
            p = $urandom_range(0, 7);
            if (!m_busy[p]) begin
                cwen = 1'b1; cslot = slot; cwaddr = p;
            end
        end
        step(dv, preg, lat, ardy, slot, cwen, cslot, cwaddr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Latency 3 timing and WAW hold until the cycle after commit.
        step(1'b1, 7, 3, 1'b1, 2, 1'b0, 0, 0);
        check_eq("b_fire", o_rdy, 1);
        idle(); check_eq("b_t1_fill", o_fill, 0);
        idle(); check_eq("b_t2_fill", o_fill, 0);
        idle(); check_eq("b_t3_fill", o_fill, 1); check_eq("b_t3_slot", o_fslot, 2);
        step(1'b1, 7, 2, 1'b1, 8, 1'b0, 0, 0); check_eq("b_waw_block", o_rdy, 0);
        step(1'b1, 7, 2, 1'b1, 8, 1'b1, 2, 7); check_eq("b_commit_cycle", o_rdy, 0);
        step(1'b1, 7, 2, 1'b1, 8, 1'b0, 0, 0); check_eq("b_unblock", o_rdy, 1);
        repeat (4) idle();

        // Full tracker blocks the fifth dispatch until the cycle after a fill.
        do_reset();
        for (int k = 0; k < 4; k++) step(1'b1, k + 1, 15, 1'b1, 3 + k, 1'b0, 0, 0);
        step(1'b1, 5, 15, 1'b1, 9, 1'b0, 0, 0);
        check_eq("c_full_rdy", o_rdy, 0);
        check_eq("c_full_val", o_req, 0);
        check_eq("c_full_cnt", o_cnt, 4);
        for (int n = 0; n < 30 && !o_fill; n++) step(1'b1, 5, 1, 1'b1, 9, 1'b0, 0, 0);
        check_eq("c_fill_seen", o_fill, 1);
        check_eq("c_fill_cycle_rdy", o_rdy, 0);
        step(1'b1, 5, 1, 1'b1, 9, 1'b0, 0, 0);
        check_eq("c_after_fill_rdy", o_rdy, 1);
        repeat (20) idle();

        // Equal due cycle: one fill per cycle in index order.
        do_reset();
        step(1'b1, 10, 3, 1'b1, 0, 1'b0, 0, 0);
        step(1'b1, 11, 2, 1'b1, 1, 1'b0, 0, 0);
        step(1'b1, 12, 1, 1'b1, 2, 1'b0, 0, 0);
        idle(); check_eq("d_t3_fill", o_fill, 1); check_eq("d_t3_slot", o_fslot, 0);
        idle(); check_eq("d_t4_fill", o_fill, 1); check_eq("d_t4_slot", o_fslot, 1);
        idle(); check_eq("d_t5_fill", o_fill, 1); check_eq("d_t5_slot", o_fslot, 2);
        idle(); check_eq("d_t6_fill", o_fill, 0);

        // ROB not ready: nothing captured, preg 9 stays free.
        do_reset();
        step(1'b1, 9, 4, 1'b0, 3, 1'b0, 0, 0);
        check_eq("e_rdy", o_rdy, 0);
        check_eq("e_req_val", o_req, 1);
        idle(); check_eq("e_cnt", o_cnt, 0);
        step(1'b1, 9, 4, 1'b1, 3, 1'b0, 0, 0);
        check_eq("e_preg9_free", o_rdy, 1);
        repeat (6) idle();

        // Latency 0 on preg 0: next-cycle fill, preg 0 never blocks.
        do_reset();
        step(1'b1, 0, 0, 1'b1, 5, 1'b0, 0, 0);
        step(1'b1, 0, 0, 1'b1, 6, 1'b0, 0, 0);
        check_eq("f_fill", o_fill, 1);
        check_eq("f_slot", o_fslot, 5);
        check_eq("f_preg0_rdy", o_rdy, 1);
        idle(); check_eq("f_fill2_slot", o_fslot, 6);

        // Reset with two entries pending discards them.
        do_reset();
        step(1'b1, 20, 15, 1'b1, 4, 1'b0, 0, 0);
        step(1'b1, 21, 15, 1'b1, 5, 1'b0, 0, 0);
        idle(); check_eq("g_pending", o_cnt, 2);
        do_reset();
        idle(); check_eq("g_rdy_after", o_rdy, 1);
        repeat (20) idle();

        // Randomized traffic with a reset in the middle.
        do_reset();
        for (int it = 0; it < 800; it++) begin
            if (it == 400) begin
                do_reset();
                idle();
                check_eq("rand_rst_rdy", o_rdy, 1);
            end
            rand_step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
